fifo_rd_stream: RTL and testbench

//  Read-side drain for the FIFO RAM addressed by the FIFO pointer controller.
//  - Issues pop strobes to the FIFO and absorbs the synchronous RAM read latency.
//  - Re-presents the words as a valid/ready stream to the SDRAM write-data path.
//  - Sustains 1 word/clk with no bubbles, and never pops a word it cannot store.

---
 rtl/fifo_pkg.sv | 42 ++++
 rtl/rd_latency_pipe.sv | 52 +++++
 rtl/fifo_rd_stream.sv | 126 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side logic.
//
// Contents:
//   MaxReadLatency  largest supported RAM read latency (1..3)
//   MaxBufDepth     largest output buffer (MaxReadLatency + 1)
//   data_t          beat type at the default 8-bit word width
//   ptr_t           circular-buffer pointer: index plus wrap bit
//   clog2_level()   width of a 0..depth occupancy count
//   ptr_inc()       advance a pointer modulo depth, toggling wrap on rollover
package fifo_pkg;

    localparam int unsigned MaxReadLatency   = 3;
    localparam int unsigned MaxBufDepth      = MaxReadLatency + 1;
    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned IdxWidth         = $clog2(MaxBufDepth);

    typedef logic [DefaultDataWidth-1:0] data_t;

    // The wrap bit makes full (wrap differs, idx equal) distinguishable from empty.
    typedef struct packed {
        logic                wrap;
        logic [IdxWidth-1:0] idx;
    } ptr_t;

    function automatic int unsigned clog2_level(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Depth need not be a power of two, so the index wraps explicitly.
    function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned depth);
        ptr_t n;
        if (32'(p.idx) == depth - 1) begin
            n.idx  = '0;
            n.wrap = ~p.wrap;
        end else begin
            n.idx  = p.idx + IdxWidth'(1);
            n.wrap = p.wrap;
        end
        return n;
    endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid-tracking shift register that mirrors the FIFO RAM read latency.
//
// Ports:
//   i_clk       clock, all logic on posedge
//   i_rst       synchronous active-high reset, clears every stage
//   i_clear     synchronous clear, discards outstanding reads
//   i_issue     a pop was issued this clock
//   o_ret       read data returning this clock (last stage)
//   o_inflight  number of issued pops whose data has not yet been written
module rd_latency_pipe
    import fifo_pkg::*;
#(
    parameter int unsigned Depth = 1,
    localparam int unsigned CntW = clog2_level(Depth)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_issue,
    output logic            o_ret,
    output logic [CntW-1:0] o_inflight
);

    logic [Depth-1:0] pipe_q;
    logic [Depth-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = i_issue;
        for (int i = 1; i < Depth; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    always_comb begin
        o_inflight = '0;
        for (int i = 0; i < Depth; i++) begin
            o_inflight = o_inflight + CntW'(pipe_q[i]);
        end
    end

    assign o_ret = pipe_q[Depth-1];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain for the FIFO RAM: issues pops, absorbs the RAM read latency
// and re-presents the words as a valid/ready stream with no bubbles.
//
// Optional feature: define FIFO_RD_STREAM_FLUSH_EN to add i_flush, which
// empties the output buffer and discards in-flight reads in one clock.
//
// Ports:
//   i_clk           clock, all logic on posedge
//   i_rst           synchronous active-high reset
//   i_fifo_empty    FIFO empty flag
//   o_fifo_rd_en    pop strobe to the FIFO
//   i_fifo_rd_data  RAM read data, ReadLatency clocks after the pop
//   o_valid         o_data holds a beat
//   i_ready         sink accepts the beat when o_valid && i_ready
//   o_data          oldest buffered word
//   o_level         words held in the buffer (excluding in-flight reads)
//   i_flush         (FIFO_RD_STREAM_FLUSH_EN only) drop buffer and in-flight reads
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned ReadLatency = 1,
    localparam int unsigned BufDepth   = ReadLatency + 1,
    localparam int unsigned LevelW     = clog2_level(BufDepth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [DataWidth-1:0] i_fifo_rd_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DataWidth-1:0] o_data,
    output logic [LevelW-1:0]    o_level
`ifdef FIFO_RD_STREAM_FLUSH_EN
    ,
    input  logic                 i_flush
`endif
);

    localparam int unsigned InflW   = clog2_level(ReadLatency);
    localparam int unsigned BufIdxW = $clog2(BufDepth);

    logic flush;
`ifdef FIFO_RD_STREAM_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    logic             ret;
    logic [InflW-1:0] inflight;
    logic             pop;
    logic             wr_en;
    logic             buf_empty;
    logic             buf_full;
    int unsigned      level_int;

    ptr_t wr_ptr_q;
    ptr_t rd_ptr_q;

    logic [DataWidth-1:0] mem_q [BufDepth];

    rd_latency_pipe #(
        .Depth (ReadLatency)
    ) u_pipe (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (flush),
        .i_issue    (o_fifo_rd_en),
        .o_ret      (ret),
        .o_inflight (inflight)
    );

    always_comb begin
        if (wr_ptr_q.wrap == rd_ptr_q.wrap) begin
            level_int = 32'(wr_ptr_q.idx) - 32'(rd_ptr_q.idx);
        end else begin
            level_int = BufDepth + 32'(wr_ptr_q.idx) - 32'(rd_ptr_q.idx);
        end
    end

    assign buf_empty = (wr_ptr_q == rd_ptr_q);
    assign buf_full  = (wr_ptr_q.wrap != rd_ptr_q.wrap) && (wr_ptr_q.idx == rd_ptr_q.idx);

    assign o_valid = !buf_empty;
    assign o_data  = mem_q[BufIdxW'(rd_ptr_q.idx)];
    assign o_level = LevelW'(level_int);

    assign pop   = o_valid && i_ready;
    assign wr_en = ret && !flush;

    // Reserve a slot for every outstanding read; a same-clock pop frees one,
    // which is what keeps the stream at one word per clock.
    assign o_fifo_rd_en = !i_rst && !flush && !i_fifo_empty &&
                          (level_int + 32'(inflight) < BufDepth + 32'(pop));

    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q, BufDepth);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q, BufDepth);
            end
        end
    end

    // Storage is cleared on reset so o_data reads zero out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BufDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[BufIdxW'(wr_ptr_q.idx)] <= i_fifo_rd_data;
        end
    end

    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst) !(wr_en && buf_full))
        else $error("fifo_rd_stream: write into full buffer");

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic rst     = 1'b1;
    logic ready_a = 1'b0;
    logic ready_b = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;

    // FIFO model A (ReadLatency 1)
    logic [7:0] mem_a [0:255];
    int         head_a = 0;
    int         tail_a = 0;
    logic       empty_a;
    logic [7:0] rd_a = 8'h00;
    logic       rd_en_a;
    logic       valid_a;
    logic [7:0] data_a;
    logic [1:0] level_a;

    // FIFO model B (ReadLatency 3)
    logic [7:0] mem_b [0:255];
    int         head_b = 0;
    int         tail_b = 0;
    logic       empty_b;
    logic [7:0] d0_b = 8'h00;
    logic [7:0] d1_b = 8'h00;
    logic [7:0] d2_b = 8'h00;
    logic       rd_en_b;
    logic       valid_b;
    logic [7:0] data_b;
    logic [2:0] level_b;

    assign empty_a = (head_a == tail_a);
    assign empty_b = (head_b == tail_b);

    always @(posedge clk) begin
        if (rd_en_a) begin
            rd_a   <= mem_a[head_a];
            head_a <= head_a + 1;
        end
        if (rd_en_b) begin
            d0_b   <= mem_b[head_b];
            head_b <= head_b + 1;
        end
        d1_b <= d0_b;
        d2_b <= d1_b;
    end

    fifo_rd_stream #(
        .DataWidth   (8),
        .ReadLatency (1)
    ) dut_a (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_fifo_empty   (empty_a),
        .o_fifo_rd_en   (rd_en_a),
        .i_fifo_rd_data (rd_a),
        .o_valid        (valid_a),
        .i_ready        (ready_a),
        .o_data         (data_a),
        .o_level        (level_a)
`ifdef FIFO_RD_STREAM_FLUSH_EN
        ,
        .i_flush        (flush_a)
`endif
    );

    fifo_rd_stream #(
        .DataWidth   (8),
        .ReadLatency (3)
    ) dut_b (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_fifo_empty   (empty_b),
        .o_fifo_rd_en   (rd_en_b),
        .i_fifo_rd_data (d2_b),
        .o_valid        (valid_b),
        .i_ready        (ready_b),
        .o_data         (data_b),
        .o_level        (level_b)
`ifdef FIFO_RD_STREAM_FLUSH_EN
        ,
        .i_flush        (flush_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] w);
        mem_a[tail_a] = w;
        tail_a = tail_a + 1;
    endtask

    task automatic push_b(input logic [7:0] w);
        mem_b[tail_b] = w;
        tail_b = tail_b + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (valid_a !== 1'b0 || level_a !== 2'd0 || data_a !== 8'h00 || rd_en_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a got v=%b l=%0d d=%h en=%b exp 0 0 00 0",
                     valid_a, level_a, data_a, rd_en_a);
        end
        checks++;
        if (valid_b !== 1'b0 || level_b !== 3'd0 || data_b !== 8'h00 || rd_en_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b got v=%b l=%0d d=%h en=%b exp 0 0 00 0",
                     valid_b, level_b, data_b, rd_en_b);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_two_words();
        ready_a = 1'b1;
        push_a(8'h11);
        push_a(8'h22);
        #1;
        checks++;
        if (rd_en_a !== 1'b1) begin
            failures++;
            $display("FAIL two_en_c0 got=%b exp=1", rd_en_a);
        end
        step();
        checks++;
        if (rd_en_a !== 1'b1 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL two_c1 got en=%b v=%b exp en=1 v=0", rd_en_a, valid_a);
        end
        step();
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h11 || level_a !== 2'd1 || rd_en_a !== 1'b0) begin
            failures++;
            $display("FAIL two_c2 got v=%b d=%h l=%0d en=%b exp v=1 d=11 l=1 en=0",
                     valid_a, data_a, level_a, rd_en_a);
        end
        step();
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h22) begin
            failures++;
            $display("FAIL two_c3 got v=%b d=%h exp v=1 d=22", valid_a, data_a);
        end
        step();
        checks++;
        if (valid_a !== 1'b0 || level_a !== 2'd0) begin
            failures++;
            $display("FAIL two_c4 got v=%b l=%0d exp v=0 l=0", valid_a, level_a);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp_d;
        ready_a = 1'b1;
        for (int i = 0; i < 34; i++) push_a(8'h40 + 8'(i));
        #1;
        for (int k = 0; k < 36; k++) begin
            if (k < 34) begin
                checks++;
                if (rd_en_a !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_en k=%0d got=%b exp=1", k, rd_en_a);
                end
            end
            if (k >= 2) begin
                exp_d = 8'h40 + 8'(k - 2);
                checks++;
                if (valid_a !== 1'b1 || data_a !== exp_d) begin
                    failures++;
                    $display("FAIL stream_beat k=%0d got v=%b d=%h exp v=1 d=%h",
                             k, valid_a, data_a, exp_d);
                end
            end
            step();
        end
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got v=%b exp=0", valid_a);
        end
    endtask

    task automatic test_stall();
        int pops;
        logic [7:0] exp_d;
        pops = 0;
        ready_a = 1'b0;
        for (int i = 0; i < 6; i++) push_a(8'hC0 + 8'(i));
        #1;
        for (int k = 0; k < 10; k++) begin
            if (rd_en_a === 1'b1) pops++;
            if (k >= 2) begin
                checks++;
                if (valid_a !== 1'b1 || data_a !== 8'hC0) begin
                    failures++;
                    $display("FAIL stall_hold k=%0d got v=%b d=%h exp v=1 d=c0",
                             k, valid_a, data_a);
                end
            end
            step();
        end
        checks++;
        if (pops != 2 || level_a !== 2'd2) begin
            failures++;
            $display("FAIL stall_pops got pops=%0d l=%0d exp pops=2 l=2", pops, level_a);
        end
        ready_a = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            exp_d = 8'hC0 + 8'(j);
            checks++;
            if (valid_a !== 1'b1 || data_a !== exp_d) begin
                failures++;
                $display("FAIL stall_release j=%0d got v=%b d=%h exp v=1 d=%h",
                         j, valid_a, data_a, exp_d);
            end
            step();
        end
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL stall_end got v=%b exp=0", valid_a);
        end
    endtask

    task automatic test_latency3();
        ready_b = 1'b1;
        push_b(8'hA5);
        #1;
        checks++;
        if (rd_en_b !== 1'b1) begin
            failures++;
            $display("FAIL lat3_en_c0 got=%b exp=1", rd_en_b);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (valid_b !== 1'b0 || rd_en_b !== 1'b0) begin
                failures++;
                $display("FAIL lat3_wait c=%0d got v=%b en=%b exp v=0 en=0", c, valid_b, rd_en_b);
            end
        end
        step();
        checks++;
        if (valid_b !== 1'b1 || data_b !== 8'hA5) begin
            failures++;
            $display("FAIL lat3_c4 got v=%b d=%h exp v=1 d=a5", valid_b, data_b);
        end
        step();
        checks++;
        if (valid_b !== 1'b0) begin
            failures++;
            $display("FAIL lat3_c5 got v=%b exp=0", valid_b);
        end
    endtask

    task automatic test_reset_inflight();
        ready_b = 1'b1;
        push_b(8'hD1);
        push_b(8'hD2);
        push_b(8'hD3);
        push_b(8'hD4);
        #1;
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (rd_en_b !== 1'b0) begin
            failures++;
            $display("FAIL rstfl_en_in_reset got=%b exp=0", rd_en_b);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (valid_b !== 1'b0 || level_b !== 3'd0 || data_b !== 8'h00 || rd_en_b !== 1'b1) begin
            failures++;
            $display("FAIL rstfl_c3 got v=%b l=%0d d=%h en=%b exp 0 0 00 1",
                     valid_b, level_b, data_b, rd_en_b);
        end
        for (int c = 4; c <= 6; c++) begin
            step();
            checks++;
            if (valid_b !== 1'b0) begin
                failures++;
                $display("FAIL rstfl_stale c=%0d got v=%b d=%h exp v=0", c, valid_b, data_b);
            end
        end
        step();
        checks++;
        if (valid_b !== 1'b1 || data_b !== 8'hD3) begin
            failures++;
            $display("FAIL rstfl_c7 got v=%b d=%h exp v=1 d=d3", valid_b, data_b);
        end
        step();
        checks++;
        if (valid_b !== 1'b1 || data_b !== 8'hD4) begin
            failures++;
            $display("FAIL rstfl_c8 got v=%b d=%h exp v=1 d=d4", valid_b, data_b);
        end
        step();
        checks++;
        if (valid_b !== 1'b0) begin
            failures++;
            $display("FAIL rstfl_c9 got v=%b exp=0", valid_b);
        end
    endtask

`ifdef FIFO_RD_STREAM_FLUSH_EN
    task automatic test_flush();
        ready_b = 1'b0;
        push_b(8'hE0);
        push_b(8'hE1);
        push_b(8'hE2);
        #1;
        repeat (5) step();
        checks++;
        if (level_b !== 3'd2 || valid_b !== 1'b1 || data_b !== 8'hE0) begin
            failures++;
            $display("FAIL flush_pre got l=%0d v=%b d=%h exp l=2 v=1 d=e0",
                     level_b, valid_b, data_b);
        end
        flush_b = 1'b1;
        step();
        flush_b = 1'b0;
        #1;
        checks++;
        if (valid_b !== 1'b0 || level_b !== 3'd0) begin
            failures++;
            $display("FAIL flush_c6 got v=%b l=%0d exp v=0 l=0", valid_b, level_b);
        end
        ready_b = 1'b1;
        push_b(8'hE3);
        #1;
        for (int c = 7; c <= 9; c++) begin
            step();
            checks++;
            if (valid_b !== 1'b0) begin
                failures++;
                $display("FAIL flush_wait c=%0d got v=%b d=%h exp v=0", c, valid_b, data_b);
            end
        end
        step();
        checks++;
        if (valid_b !== 1'b1 || data_b !== 8'hE3) begin
            failures++;
            $display("FAIL flush_c10 got v=%b d=%h exp v=1 d=e3", valid_b, data_b);
        end
        step();
        checks++;
        if (valid_b !== 1'b0) begin
            failures++;
            $display("FAIL flush_c11 got v=%b exp=0", valid_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_stream();
        test_stall();
        test_latency3();
        test_reset_inflight();
`ifdef FIFO_RD_STREAM_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
